dma_copy_channel: RTL and testbench
===================================

Name: dma_copy_channel

Overview:
- Initiator side of the dma_req / dma_busynready handshake served by dma_access.
- Copies a block of LEN bytes from a source to a destination in the 21-bit DMA address space.
- Each byte is moved as one read transfer followed by one write transfer.
- Supports one-shot transfers (bus released between transfers) and burst transfers (dma_req held high across transfers).

Parameters:
- ADDR_W, 21, width of DMA addresses.
- LEN_W, 16, width of the length and remaining-count fields.
- GAP_CYCLES, 2, idle cycles inserted between transfers in one-shot mode; legal range 0..15.
- SRC_FIXED, 0, 1 = source address is not incremented (port-like source).
- DST_FIXED, 0, 1 = destination address is not incremented.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; latches src_addr, dst_addr, len, burst. Ignored while busy=1.
- src_addr  in  ADDR_W  first source address.
- dst_addr  in  ADDR_W  first destination address.
- len  in  LEN_W  byte count; 0 means no transfers.
- burst  in  1  1 = burst mode, 0 = one-shot mode.
- abort  in  1  pulse or level; stops the copy at the next transfer boundary.
- busy  out  1  copy in progress.
- done  out  1  one-cycle pulse when the copy ends, whether completed or aborted.
- aborted  out  1  set together with done if the copy ended by abort; held until the next start.
- remaining  out  LEN_W  bytes not yet written.
- dma_req  out  1  transfer request to dma_access.
- dma_rnw  out  1  1 = read, 0 = write.
- dma_addr  out  ADDR_W  transfer address.
- dma_wd  out  8  write data.
- dma_rd  in  8  read data; valid in the completion cycle.
- dma_busynready  in  1  1 = dma_access busy with a transfer.

Behaviour:
- Reset, sampled at a clock edge with rst_n=0: state=IDLE, and the next cycle shows busy=0, done=0, aborted=0, remaining=0, dma_req=0, dma_rnw=1, dma_addr=0, dma_wd=0. This applies mid-transfer as well; no completion wait, no done pulse.
- Handshake definitions:
  - accept = dma_req=1 and dma_busynready rises (registered previous value 0, current value 1).
  - completion = dma_busynready falls (previous 1, current 0) while a transfer is outstanding.
  - dma_rnw, dma_addr and dma_wd are registered and stay stable from dma_req assertion until completion.
- States:
  - IDLE: on start, latch the inputs. If len=0, pulse done in the next cycle and stay idle (busy stays 0). Otherwise go to RD with remaining=len and busy=1.
  - RD: dma_req=1, dma_rnw=1, dma_addr=src.
    - One-shot mode: drop dma_req the clock after accept.
    - On completion: capture dma_rd into the data register, increment src (modulo 2^ADDR_W) unless SRC_FIXED, go to WR.
    - In burst mode dma_req stays 1 and the WR command is presented the clock after completion.
  - WR: dma_req=1, dma_rnw=0, dma_addr=dst, dma_wd=captured byte. On completion: increment dst unless DST_FIXED, decrement remaining.
    - If the new remaining=0: go to DONE.
    - Else, if abort is set: go to DONE.
    - Else, burst mode: go to RD (dma_req stays high).
    - Else, one-shot mode: go to GAP.
  - GAP: dma_req=0 for GAP_CYCLES clocks, then RD. With GAP_CYCLES=0, RD follows directly, but dma_req is still 0 for one cycle.
  - DONE: dma_req=0, done=1 for one cycle, busy=0, then IDLE.
- Final transfer in burst mode: the last write is issued one-shot style, with dma_req dropped the clock after accept, so dma_access never sees a spurious extra request.
- Abort:
  - Latched into a sticky flag; aborted reflects this flag at DONE.
  - A transfer already requested always runs to completion.
  - Abort during RD completes both the read and the write of that byte before stopping, so no byte is ever half-copied.
- Address arithmetic wraps, e.g. 0x1FFFFF+1 = 0x000000. The remaining counter never underflows.
- start while busy=1 is ignored. Simultaneous start and abort in IDLE: start is taken and abort is ignored.
- Latency: dma_req rises the clock after start. done rises the clock after the final write completion.

Test Plan:
- One-shot copy, src=0x08001, dst=0x08100, len=3, source 11,22,33 -> three read/write pairs; dma_req low for ≥GAP_CYCLES between transfers; 0x08100..0x08102 = 11,22,33; one done pulse; remaining 3→0.
- Burst copy, len=4, with a responder model that completes each transfer in 3 cycles -> dma_req continuously high until the last write is accepted; exactly 8 completions; dma_rnw alternating 1,0,1,0...
- len=0 -> no dma_req; done pulses 1 clock after start; busy stays 0.
- Address wrap: src=0x1FFFFF, dst=0x1FFFFE, len=2 -> second read at 0x000000, second write at 0x1FFFFF.
- Abort asserted during the 2nd read of len=5 -> the 2nd write still occurs; done with aborted=1, remaining=3. A start issued while busy is ignored.
- rst_n=0 mid-burst -> dma_req=0, busy=0 and all outputs at reset values one clock later; a fresh start then works normally.

Source files
------------

// File: rtl/dma_copy_channel.sv
// dma_copy_channel: block copy engine on the dma_req / dma_busynready handshake.
// Each byte is one read transfer followed by one write transfer, issued either
// one-shot (request released between transfers, with a gap after each write)
// or as a burst (request held high across transfers, last write one-shot).
module dma_copy_channel #(
  parameter int ADDR_W     = 21,
  parameter int LEN_W      = 16,
  parameter int GAP_CYCLES = 2,
  parameter bit SRC_FIXED  = 1'b0,
  parameter bit DST_FIXED  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              burst,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  remaining,
  output logic              dma_req,
  output logic              dma_rnw,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [7:0]        dma_wd,
  input  logic [7:0]        dma_rd,
  input  logic              dma_busynready
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_GAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [7:0]        wd_q, wd_d;
  logic [3:0]        gap_q, gap_d;
  logic              burst_q, burst_d;
  logic              abort_q, abort_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              rnw_q, rnw_d;
  logic              out_q, out_d;
  logic              bnr_prev_q;

  logic              accept;
  logic              completion;
  logic              last_wr;
  logic              gap_end;
  logic              abort_hit;
  logic [LEN_W-1:0]  rem_dec;

  // Handshake edges are judged against the previous sample of dma_busynready.
  assign accept     = req_q && !bnr_prev_q && dma_busynready;
  assign completion = out_q && bnr_prev_q && !dma_busynready;
  assign last_wr    = (rem_q == LEN_W'(1));
  assign abort_hit  = abort_q || abort;
  // Saturating decrement so the counter can never wrap below zero.
  assign rem_dec    = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;
  // With GAP_CYCLES=0 this is true immediately, still leaving one idle cycle.
  assign gap_end    = ({1'b0, gap_q} + 5'd1) >= 5'(GAP_CYCLES);

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign remaining = rem_q;
  assign dma_req   = req_q;
  assign dma_rnw   = rnw_q;
  assign dma_addr  = addr_q;
  assign dma_wd    = wd_q;

  // Next-state and registered-output computation for the copy sequencer.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    burst_d   = burst_q;
    abort_d   = abort_q;
    aborted_d = aborted_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    req_d     = req_q;
    rnw_d     = rnw_q;
    out_d     = out_q;

    if (accept) begin
      out_d = 1'b1;
    end
    if (completion) begin
      out_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d     = src_addr;
          dst_d     = dst_addr;
          burst_d   = burst;
          rem_d     = len;
          abort_d   = 1'b0;
          aborted_d = 1'b0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RD;
            busy_d  = 1'b1;
            req_d   = 1'b1;
            rnw_d   = 1'b1;
            addr_d  = src_addr;
          end
        end
      end

      S_RD: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        if (accept && !burst_q) begin
          req_d = 1'b0;
        end
        if (completion) begin
          wd_d    = dma_rd;
          src_d   = SRC_FIXED ? src_q : src_q + ADDR_W'(1);
          state_d = S_WR;
          req_d   = 1'b1;
          rnw_d   = 1'b0;
          addr_d  = dst_q;
        end
      end

      S_WR: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        // A write known to be the final one is released once accepted so a
        // burst never leaves a stray request behind.
        if ((accept || out_q) && (!burst_q || last_wr || abort_q)) begin
          req_d = 1'b0;
        end
        if (completion) begin
          dst_d = DST_FIXED ? dst_q : dst_q + ADDR_W'(1);
          rem_d = rem_dec;
          if ((rem_dec == '0) || abort_hit) begin
            state_d   = S_DONE;
            req_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = abort_hit;
          end else if (burst_q) begin
            state_d = S_RD;
            req_d   = 1'b1;
            rnw_d   = 1'b1;
            addr_d  = src_q;
          end else begin
            state_d = S_GAP;
            req_d   = 1'b0;
            gap_d   = 4'd0;
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        if (gap_end) begin
          state_d = S_RD;
          req_d   = 1'b1;
          rnw_d   = 1'b1;
          addr_d  = src_q;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      wd_q       <= '0;
      gap_q      <= '0;
      burst_q    <= 1'b0;
      abort_q    <= 1'b0;
      aborted_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      rnw_q      <= 1'b1;
      out_q      <= 1'b0;
      bnr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      burst_q    <= burst_d;
      abort_q    <= abort_d;
      aborted_q  <= aborted_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      req_q      <= req_d;
      rnw_q      <= rnw_d;
      out_q      <= out_d;
      bnr_prev_q <= dma_busynready;
    end
  end

endmodule

// File: tb/tb_dma_copy_channel.sv
// Bench for dma_copy_channel: a 3-cycle dma_access responder logs every
// transfer; each scenario compares the log against a byte-level copy model.
module tb_dma_copy_channel;
  localparam int ADDR_W = 21;
  localparam int LEN_W = 16;
  localparam int GAP_CYCLES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              burst = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, aborted, dma_req, dma_rnw;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wd;
  logic [7:0]        dma_rd = 8'hEE;
  logic              dma_busynready = 1'b0;

  dma_copy_channel #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES),
    .SRC_FIXED(1'b0), .DST_FIXED(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .burst(burst), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .remaining(remaining),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr),
    .dma_wd(dma_wd), .dma_rd(dma_rd), .dma_busynready(dma_busynready)
  );

  typedef struct {
    logic        rnw;
    logic [20:0] addr;
    logic [7:0]  data;
    int          idle;
    int          lowtot;
  } xact_t;

  int total = 0;
  int bad = 0;
  xact_t xlog[$];
  xact_t exp_q[$];
  logic [7:0] rmem [logic [20:0]];
  logic [7:0] wmem [logic [20:0]];
  int rsp_cnt = 0;
  logic rsp_rnw = 1'b1;
  logic [20:0] rsp_addr = '0;
  logic [7:0] rsp_wd = '0;
  bit rsp_taint = 1'b0;
  int idle_cnt = 0, low_tot = 0, stab_err = 0, done_cnt = 0, comp_cnt = 0;

  // Source memory: preloaded bytes, otherwise a fixed hash of the address.
  function automatic logic [7:0] src_byte(input logic [20:0] a);
    if (rmem.exists(a)) return rmem[a];
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'hA5;
  endfunction

  // Reference model: a copy of n bytes is n (read src+i, write dst+i) pairs.
  task automatic build_expected(input logic [20:0] s, input logic [20:0] d, input int n);
    xact_t x;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      x.rnw = 1'b1; x.addr = s + 21'(i); x.data = 8'h00; x.idle = 0; x.lowtot = 0;
      exp_q.push_back(x);
      x.rnw = 1'b0; x.addr = d + 21'(i); x.data = src_byte(s + 21'(i));
      exp_q.push_back(x);
    end
  endtask

  // Responder model of dma_access: 3 busy cycles per transfer.
  always @(negedge clk) begin
    xact_t x;
    if (done === 1'b1) done_cnt++;
    if (dma_req !== 1'b1) low_tot++;
    if (!rst_n) rsp_taint = 1'b1;
    if (rsp_cnt != 0) begin
      if (!rsp_taint && (dma_rnw !== rsp_rnw || dma_addr !== rsp_addr ||
          (!rsp_rnw && dma_wd !== rsp_wd)))
        stab_err++;
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        dma_busynready = 1'b0;
        comp_cnt++;
        idle_cnt = 0;
        if (rsp_rnw) dma_rd = src_byte(rsp_addr);
        else wmem[rsp_addr] = rsp_wd;
      end
    end else begin
      dma_rd = 8'hEE;
      if (dma_req === 1'b1) begin
        rsp_rnw = dma_rnw; rsp_addr = dma_addr; rsp_wd = dma_wd; rsp_taint = 1'b0;
        x.rnw = dma_rnw; x.addr = dma_addr; x.data = dma_wd; x.idle = idle_cnt; x.lowtot = low_tot;
        xlog.push_back(x);
        $display("xact %s addr=%06h wd=%02h", dma_rnw ? "rd" : "wr", dma_addr, dma_wd);
        dma_busynready = 1'b1;
        rsp_cnt = 3;
      end else begin
        idle_cnt++;
      end
    end
  end

  task automatic do_start(input logic [20:0] s, input logic [20:0] d, input logic [15:0] n, input logic b);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; burst = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, aborted, remaining, dma_req, dma_rnw, dma_addr, dma_wd} !==
        {1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 21'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b ab=%b rem=%0d req=%b rnw=%b addr=%06h wd=%02h want 0,0,0,0,0,1,0,0",
               busy, done, aborted, remaining, dma_req, dma_rnw, dma_addr, dma_wd);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one_shot;
    bit seen;
    int d0;
    logic [7:0] got;
    logic [7:0] want;
    rmem[21'h08001] = 8'h11; rmem[21'h08002] = 8'h22; rmem[21'h08003] = 8'h33;
    xlog.delete(); d0 = done_cnt; stab_err = 0;
    build_expected(21'h08001, 21'h08100, 3);
    do_start(21'h08001, 21'h08100, 16'd3, 1'b0);
    total++;
    if (busy !== 1'b1 || remaining !== 16'd3 || dma_req !== 1'b1) begin
      bad++; $display("FAIL oneshot_started got busy=%b rem=%0d req=%b want 1,3,1", busy, remaining, dma_req);
    end
    wait_done(400, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL oneshot_done got timeout want done pulse"); end
    total++;
    if (remaining !== 16'd0 || aborted !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL oneshot_end got rem=%0d ab=%b busy=%b want 0,0,0", remaining, aborted, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL oneshot_pulse got done=%b want 0", done); end
    total++;
    if (xlog.size() != exp_q.size()) begin
      bad++; $display("FAIL oneshot_count got=%0d want=%0d", xlog.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < xlog.size(); i++) begin
      total++;
      if (xlog[i].rnw !== exp_q[i].rnw || xlog[i].addr !== exp_q[i].addr ||
          (!exp_q[i].rnw && xlog[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL oneshot_xact%0d got=%b/%06h/%02h want=%b/%06h/%02h", i,
                        xlog[i].rnw, xlog[i].addr, xlog[i].data, exp_q[i].rnw, exp_q[i].addr, exp_q[i].data);
      end
      if (i > 0 && exp_q[i].rnw) begin
        total++;
        if (xlog[i].idle < GAP_CYCLES) begin
          bad++; $display("FAIL oneshot_gap%0d got=%0d want>=%0d", i, xlog[i].idle, GAP_CYCLES);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      want = 8'h11 * 8'(i + 1);
      got = wmem.exists(21'h08100 + 21'(i)) ? wmem[21'h08100 + 21'(i)] : 8'hxx;
      total++;
      if (got !== want) begin bad++; $display("FAIL oneshot_mem%0d got=%02h want=%02h", i, got, want); end
    end
    total++;
    if (done_cnt - d0 != 1 || stab_err != 0) begin
      bad++; $display("FAIL oneshot_pulses got done=%0d stab=%0d want 1,0", done_cnt - d0, stab_err);
    end
  endtask

  task automatic test_burst;
    bit seen;
    int c0;
    logic [20:0] s, d;
    s = 21'($urandom); d = 21'($urandom);
    xlog.delete(); c0 = comp_cnt; stab_err = 0;
    build_expected(s, d, 4);
    do_start(s, d, 16'd4, 1'b1);
    wait_done(400, seen);
    total++;
    if (!seen || remaining !== 16'd0) begin
      bad++; $display("FAIL burst_done got seen=%b rem=%0d want 1,0", seen, remaining);
    end
    repeat (10) @(negedge clk);
    total++;
    if (comp_cnt - c0 != 8 || xlog.size() != 8) begin
      bad++; $display("FAIL burst_count got comp=%0d log=%0d want 8,8", comp_cnt - c0, xlog.size());
    end
    for (int i = 0; i < exp_q.size() && i < xlog.size(); i++) begin
      total++;
      if (xlog[i].rnw !== exp_q[i].rnw || xlog[i].addr !== exp_q[i].addr ||
          (!exp_q[i].rnw && xlog[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL burst_xact%0d got=%b/%06h/%02h want=%b/%06h/%02h", i,
                        xlog[i].rnw, xlog[i].addr, xlog[i].data, exp_q[i].rnw, exp_q[i].addr, exp_q[i].data);
      end
    end
    if (xlog.size() > 1) begin
      total++;
      if (xlog[xlog.size() - 1].lowtot != xlog[0].lowtot || stab_err != 0) begin
        bad++; $display("FAIL burst_req_held got low_cycles=%0d stab=%0d want 0,0",
                        xlog[xlog.size() - 1].lowtot - xlog[0].lowtot, stab_err);
      end
    end
  endtask

  task automatic test_len_zero;
    int d0;
    bit stray;
    xlog.delete(); d0 = done_cnt; stray = 1'b0;
    do_start(21'($urandom), 21'($urandom), 16'd0, 1'($urandom));
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || dma_req !== 1'b0) begin
      bad++; $display("FAIL len0_done got done=%b busy=%b req=%b want 1,0,0", done, busy, dma_req);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || dma_req !== 1'b0 || done !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray || done_cnt - d0 != 1 || xlog.size() != 0) begin
      bad++; $display("FAIL len0_quiet got stray=%b done=%0d log=%0d want 0,1,0", stray, done_cnt - d0, xlog.size());
    end
  endtask

  task automatic test_wrap;
    bit seen;
    xlog.delete();
    build_expected(21'h1FFFFF, 21'h1FFFFE, 2);
    do_start(21'h1FFFFF, 21'h1FFFFE, 16'd2, 1'($urandom));
    wait_done(400, seen);
    total++;
    if (!seen || xlog.size() != 4) begin
      bad++; $display("FAIL wrap_count got seen=%b log=%0d want 1,4", seen, xlog.size());
    end
    for (int i = 0; i < exp_q.size() && i < xlog.size(); i++) begin
      total++;
      if (xlog[i].rnw !== exp_q[i].rnw || xlog[i].addr !== exp_q[i].addr ||
          (!exp_q[i].rnw && xlog[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL wrap_xact%0d got=%b/%06h/%02h want=%b/%06h/%02h", i,
                        xlog[i].rnw, xlog[i].addr, xlog[i].data, exp_q[i].rnw, exp_q[i].addr, exp_q[i].data);
      end
    end
    if (xlog.size() == 4) begin
      total++;
      if (xlog[2].addr !== 21'h000000 || xlog[3].addr !== 21'h1FFFFF) begin
        bad++; $display("FAIL wrap_addr got rd=%06h wr=%06h want 000000,1fffff", xlog[2].addr, xlog[3].addr);
      end
    end
  endtask

  task automatic test_abort;
    bit seen;
    logic [20:0] s, d;
    s = 21'($urandom); d = 21'($urandom);
    xlog.delete();
    build_expected(s, d, 2);
    do_start(s, d, 16'd5, 1'($urandom));
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (xlog.size() >= 3) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL abort_second_read got timeout want read accepted"); end
    abort = 1'b1; start = 1'b1; src_addr = s + 21'h100; dst_addr = d + 21'h100; len = 16'd9;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    wait_done(400, seen);
    total++;
    if (!seen || aborted !== 1'b1 || remaining !== 16'd3) begin
      bad++; $display("FAIL abort_end got seen=%b ab=%b rem=%0d want 1,1,3", seen, aborted, remaining);
    end
    repeat (3) @(negedge clk);
    total++;
    if (xlog.size() != 4 || aborted !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_after got log=%0d ab=%b busy=%b want 4,1,0", xlog.size(), aborted, busy);
    end
    for (int i = 0; i < exp_q.size() && i < xlog.size(); i++) begin
      total++;
      if (xlog[i].rnw !== exp_q[i].rnw || xlog[i].addr !== exp_q[i].addr ||
          (!exp_q[i].rnw && xlog[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL abort_xact%0d got=%b/%06h/%02h want=%b/%06h/%02h", i,
                        xlog[i].rnw, xlog[i].addr, xlog[i].data, exp_q[i].rnw, exp_q[i].addr, exp_q[i].data);
      end
    end
    do_start(s, d, 16'd0, 1'b0);
    total++;
    if (aborted !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL abort_cleared got ab=%b done=%b want 0,1", aborted, done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit seen;
    int d0;
    logic [20:0] s, d;
    s = 21'($urandom); d = 21'($urandom);
    xlog.delete(); d0 = done_cnt;
    do_start(s, d, 16'd6, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (xlog.size() >= 3) begin seen = 1'b1; break; end
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (!seen || {busy, done, aborted, remaining, dma_req, dma_rnw, dma_addr, dma_wd} !==
        {1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 21'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_mid got seen=%b busy=%b done=%b ab=%b rem=%0d req=%b rnw=%b addr=%06h wd=%02h want 1,0,0,0,0,0,1,0,0",
               seen, busy, done, aborted, remaining, dma_req, dma_rnw, dma_addr, dma_wd);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20 && rsp_cnt != 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt != d0 || busy !== 1'b0 || dma_req !== 1'b0) begin
      bad++; $display("FAIL reset_mid_quiet got done=%0d busy=%b req=%b want 0,0,0", done_cnt - d0, busy, dma_req);
    end
    s = 21'($urandom); d = 21'($urandom);
    xlog.delete();
    build_expected(s, d, 3);
    do_start(s, d, 16'd3, 1'b1);
    wait_done(400, seen);
    total++;
    if (!seen || xlog.size() != 6 || remaining !== 16'd0) begin
      bad++; $display("FAIL reset_fresh got seen=%b log=%0d rem=%0d want 1,6,0", seen, xlog.size(), remaining);
    end
    for (int i = 0; i < exp_q.size() && i < xlog.size(); i++) begin
      total++;
      if (xlog[i].rnw !== exp_q[i].rnw || xlog[i].addr !== exp_q[i].addr ||
          (!exp_q[i].rnw && xlog[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL reset_fresh_xact%0d got=%b/%06h/%02h want=%b/%06h/%02h", i,
                        xlog[i].rnw, xlog[i].addr, xlog[i].data, exp_q[i].rnw, exp_q[i].addr, exp_q[i].data);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    bit seen;
    int n;
    logic b;
    logic [20:0] s, d;
    for (int it = 0; it < 6; it++) begin
      s = 21'($urandom); d = 21'($urandom);
      n = $urandom_range(1, 5); b = 1'($urandom);
      xlog.delete(); stab_err = 0;
      build_expected(s, d, n);
      do_start(s, d, 16'(n), b);
      wait_done(400, seen);
      total++;
      if (!seen || xlog.size() != 2 * n || remaining !== 16'd0 || stab_err != 0) begin
        bad++; $display("FAIL rand%0d_end got seen=%b log=%0d rem=%0d stab=%0d want 1,%0d,0,0",
                        it, seen, xlog.size(), remaining, stab_err, 2 * n);
      end
      for (int i = 0; i < exp_q.size() && i < xlog.size(); i++) begin
        total++;
        if (xlog[i].rnw !== exp_q[i].rnw || xlog[i].addr !== exp_q[i].addr ||
            (!exp_q[i].rnw && xlog[i].data !== exp_q[i].data)) begin
          bad++; $display("FAIL rand%0d_xact%0d got=%b/%06h/%02h want=%b/%06h/%02h", it, i,
                          xlog[i].rnw, xlog[i].addr, xlog[i].data, exp_q[i].rnw, exp_q[i].addr, exp_q[i].data);
        end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_burst();
    test_len_zero();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
